// File: rtl/MD_pkg.sv
// Shared packet layout, broadcast node id and egress FSM states for partial-force transmit.
package MD_pkg;

    localparam int CELL_ID_WIDTH     = 3;
    localparam int PARTICLE_ID_WIDTH = 8;
    localparam int FORCE_WIDTH       = 32;
    localparam int NODE_ID_WIDTH     = 4;

    // Packet layout, LSB first: force x/y/z, particle id, cell id (3 coords)
    localparam int FRC_FORCE_LSB        = 0;
    localparam int FRC_PID_LSB          = FRC_FORCE_LSB + 3 * FORCE_WIDTH;
    localparam int FRC_CELL_LSB         = FRC_PID_LSB + PARTICLE_ID_WIDTH;
    localparam int FRC_PKT_STRUCT_WIDTH = FRC_CELL_LSB + 3 * CELL_ID_WIDTH;

    localparam logic [NODE_ID_WIDTH-1:0] NODE_ID_BCAST = '1;

    typedef enum logic [1:0] {
        PTX_IDLE,
        PTX_DRAIN,
        PTX_SEND_LAST
    } ptx_state_t;

    // True when every force component is +0 or -0 (sign bits ignored).
    function automatic logic force_is_zero(input logic [FRC_PKT_STRUCT_WIDTH-1:0] pkt);
        logic [FRC_PKT_STRUCT_WIDTH-1:0] mag_mask;
        mag_mask = '0;
        for (int i = 0; i < 3; i++) begin
            mag_mask[FRC_FORCE_LSB + i * FORCE_WIDTH +: FORCE_WIDTH - 1] = '1;
        end
        return (pkt & mag_mask) == '0;
    endfunction

endpackage

// File: rtl/partial_force_tx_fifo.sv
// Synchronous FIFO for egress partial-force packets (module frc_tx_fifo).
module frc_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/partial_force_tx.sv
// Egress buffer for released partial-force packets toward the inter-FPGA router.
// Optional PFTX_ZERO_DROP_EN: packets with all-zero force are discarded at the input.
module partial_force_tx
    import MD_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            nb_frc_release_valid,
    input  logic [FRC_PKT_STRUCT_WIDTH-1:0] nb_frc_release,
    input  logic [NODE_ID_WIDTH-1:0]        node_id_release,
    input  logic                            iter_done,
    output logic [FRC_PKT_STRUCT_WIDTH-1:0] tx_data,
    output logic [NODE_ID_WIDTH-1:0]        tx_dest,
    output logic                            tx_last,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            almost_full,
    output logic                            overflow,
    output logic [15:0]                     tx_cnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned RW = $clog2(DEPTH + 2);
    localparam int unsigned PW = NODE_ID_WIDTH + FRC_PKT_STRUCT_WIDTH;

    ptx_state_t                      state_q, state_d;
    logic [RW-1:0]                   drain_rem_q, drain_rem_d;
    logic [RW-1:0]                   drain_init;
    logic                            out_valid_q;
    logic [FRC_PKT_STRUCT_WIDTH-1:0] out_data_q;
    logic [NODE_ID_WIDTH-1:0]        out_dest_q;
    logic                            overflow_q;
    logic [15:0]                     tx_cnt_q;
    logic [FRC_PKT_STRUCT_WIDTH-1:0] term_data;

    logic          keep, wr_en, load_allow, fifo_pop, fifo_full, fifo_empty;
    logic [PW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          xfer_data, xfer_last;

`ifdef PFTX_ZERO_DROP_EN
    assign keep = !force_is_zero(nb_frc_release);
`else
    assign keep = 1'b1;
`endif

    assign xfer_data = out_valid_q && tx_ready;
    assign xfer_last = (state_q == PTX_SEND_LAST) && tx_ready;

    // In DRAIN only packets counted at iter_done may reach the output register.
    always_comb begin
        load_allow = 1'b0;
        unique case (state_q)
            PTX_IDLE:      load_allow = 1'b1;
            PTX_DRAIN:     load_allow = drain_rem_q > RW'(out_valid_q);
            PTX_SEND_LAST: load_allow = 1'b0;
            default:       load_allow = 1'b0;
        endcase
    end

    assign fifo_pop = (!out_valid_q || tx_ready) && !fifo_empty && load_allow;
    assign wr_en    = nb_frc_release_valid && keep && (!fifo_full || fifo_pop);

    frc_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .wdata ({node_id_release, nb_frc_release}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Packets still owed this iteration after this cycle's transfer and write.
    assign drain_init = RW'(fifo_count) + RW'(out_valid_q) + RW'(wr_en) - RW'(xfer_data);

    always_comb begin
        state_d     = state_q;
        drain_rem_d = drain_rem_q;
        unique case (state_q)
            PTX_IDLE: begin
                if (iter_done) begin
                    drain_rem_d = drain_init;
                    state_d     = (drain_init == '0) ? PTX_SEND_LAST : PTX_DRAIN;
                end
            end
            PTX_DRAIN: begin
                if (xfer_data) begin
                    drain_rem_d = drain_rem_q - 1'b1;
                    if (drain_rem_q == RW'(1)) state_d = PTX_SEND_LAST;
                end
            end
            PTX_SEND_LAST: begin
                if (tx_ready) state_d = PTX_IDLE;
            end
            default: state_d = PTX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PTX_IDLE;
            drain_rem_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            overflow_q  <= 1'b0;
            tx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            drain_rem_q <= drain_rem_d;
            if (fifo_pop) begin
                {out_dest_q, out_data_q} <= fifo_rdata;
                out_valid_q              <= 1'b1;
            end else if (xfer_data) begin
                out_valid_q <= 1'b0;
            end
            if (nb_frc_release_valid && keep && !wr_en) overflow_q <= 1'b1;
            if (xfer_last) begin
                tx_cnt_q <= '0;
            end else if (xfer_data && (tx_cnt_q != 16'hFFFF)) begin
                tx_cnt_q <= tx_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        term_data = '0;
        term_data[FRC_PID_LSB +: PARTICLE_ID_WIDTH] = tx_cnt_q[PARTICLE_ID_WIDTH-1:0];
    end

    assign tx_last     = (state_q == PTX_SEND_LAST);
    assign tx_valid    = out_valid_q || tx_last;
    assign tx_data     = tx_last ? term_data : out_data_q;
    assign tx_dest     = tx_last ? NODE_ID_BCAST : out_dest_q;
    assign almost_full = fifo_count >= CW'(DEPTH - AFULL_MARGIN);
    assign overflow    = overflow_q;
    assign tx_cnt      = tx_cnt_q;

endmodule
